adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one 32-bit adder_subtracter between two requesters using valid/ready handshakes and round-robin arbitration.
- The adder is gate-level and multi-cycle to settle, so the block holds its operands and command stable for a programmable number of cycles, then captures the result.
- It returns result, carryout and overflow on a single response channel tagged with the requester ID.
- Sits between ALU-using sequencers and the shared adder instance.

Parameters:
- WIDTH, 32, operand/result width; must match the shared adder.
- SETTLE_CYCLES, 4, cycles operands are held before capture; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  bit i = requester i has an operation
- req_ready  output  2  bit i = requester i accepted this cycle
- req_a  input  2*WIDTH  operand A; [WIDTH-1:0] = requester 0, upper half = requester 1
- req_b  input  2*WIDTH  operand B, same packing
- req_sub  input  2  1 = A-B, 0 = A+B
- alu_a  output  WIDTH  to shared adder operand A
- alu_b  output  WIDTH  to shared adder operand B
- alu_cmd  output  3  to shared adder command; 3'b000 add, 3'b001 subtract
- alu_result  input  WIDTH  from shared adder
- alu_carryout  input  1  from shared adder
- alu_overflow  input  1  from shared adder
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the response
- rsp_result  output  WIDTH  captured sum/difference
- rsp_carryout  output  1  captured carryout
- rsp_overflow  output  1  captured signed overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_carryout=0; rsp_overflow=0; alu_a=0; alu_b=0; alu_cmd=3'b000; last_grant=1, so requester 0 wins first; settle counter=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - grant = the valid requester; if both are valid, the one != last_grant.
  - req_ready[grant] is asserted combinationally; the other bit is 0.
  - On the accept edge: latch alu_a/alu_b from the granted slice; alu_cmd={2'b00,req_sub[grant]}; rsp_id=grant; last_grant=grant; counter=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - req_ready=2'b00; alu_* held stable.
  - Counter decrements each cycle.
  - On the edge where counter==0: capture alu_result, alu_carryout and alu_overflow into rsp_*; go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid drops the next cycle; go to IDLE. No new accept happens in that same cycle.
- Latency: rsp_valid rises exactly SETTLE_CYCLES clocks after the accept edge; throughput is one operation per SETTLE_CYCLES+2 cycles at best.
- alu_a/alu_b/alu_cmd keep their last values in IDLE and RESP, so there is no spurious adder toggling.
- req_valid changes during SETTLE or RESP are ignored; the requester holds its request until it sees req_ready.
- Both requesters continuously valid: grants alternate 0,1,0,1...
- Single requester continuously valid: it is granted every transaction.
- Reset mid-operation: the transaction is discarded and no response is produced; requesters reissue.
- Widths: captured values pass through unmodified; the block performs no arithmetic of its own.

Optional Feature:
- Macro: ADDER_ARBITER_SATURATE_EN.
- Defined: at capture, if alu_overflow=1, rsp_result = alu_a[WIDTH-1] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. rsp_overflow still reports 1 and rsp_carryout is unchanged.
- Undefined: rsp_result = alu_result, a wrapped two's-complement value.

Test Plan (adder model settles within SETTLE_CYCLES):
- req0 add 0x00000001+0x00000001 -> req_ready[0] for 1 cycle; rsp_valid 4 clocks after accept; rsp_result=0x00000002, carryout=0, overflow=0, rsp_id=0.
- Both valid continuously; req0 adds 1+1, req1 subtracts 0x00200000-0x00000080 -> responses in order id 0 (0x00000002), id 1 (0x001FFF80, carryout=1), then id 0 again; req_ready never 2'b11.
- req1 sub 0x80000001-0x80000001 -> rsp_result=0x00000000, carryout=1, overflow=0, rsp_id=1.
- req0 add 0x7FFFFFFF+0x00000001 -> overflow=1; result=0x80000000 without the macro, 0x7FFFFFFF with ADDER_ARBITER_SATURATE_EN.
- Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid low next cycle, next grant the cycle after.
- Assert rst_n=0 during SETTLE -> outputs at reset values immediately; after release, no response for the aborted operation and requester 0 is granted first.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one multi-cycle 32-bit adder/subtracter between two requesters.
// Optional build macro ADDER_ARBITER_SATURATE_EN saturates the captured result on signed overflow.
module adder_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_sub,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_cmd,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

`ifdef ADDER_ARBITER_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               alu_sub_q, alu_sub_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               grant;
  logic               accept;

  // With both requesting, the one that did not win last time goes next.
  assign grant  = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign accept = (state_q == IDLE) && (|req_valid);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sub_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sub_q    <= alu_sub_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid)     state_d = SETTLE;
      SETTLE:  if (cnt_q == 8'd0)  state_d = RESP;
      RESP:    if (rsp_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sub_d    = alu_sub_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;

    if (accept) begin
      alu_a_d      = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      alu_b_d      = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      alu_sub_d    = req_sub[grant];
      rsp_id_d     = grant;
      last_grant_d = grant;
      cnt_d        = CNT_INIT;
    end

    if (state_q == SETTLE) begin
      if (cnt_q == 8'd0) begin
        rsp_carry_d = alu_carryout;
        rsp_ovf_d   = alu_overflow;
`ifdef ADDER_ARBITER_SATURATE_EN
        // Clamp toward the sign of operand A; flags still report the raw adder outcome.
        if (alu_overflow) rsp_result_d = alu_a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
        else              rsp_result_d = alu_result;
`else
        rsp_result_d = alu_result;
`endif
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && state_q == IDLE) req_ready = (grant ? 2'b10 : 2'b01) & req_valid;
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cmd      = {2'b00, alu_sub_q};

endmodule
